// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU issue/capture sequencer: opcode encodings,
// FSM state type and the opcode legality test.
package alu_op_sequencer_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'd0;
   localparam logic [OP_W-1:0] OP_OR  = 3'd1;
   localparam logic [OP_W-1:0] OP_AND = 3'd2;
   localparam logic [OP_W-1:0] OP_SUB = 3'd3;
   localparam logic [OP_W-1:0] OP_SLT = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } seq_state_t;

   // Opcodes 101..111 have no ALU function behind them.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return (op <= OP_SLT);
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the sequencer's issue side, ALU side and result side.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender holds valid and its payload until that edge; ready
// may be asserted without valid and carries no commitment by itself.
interface alu_op_sequencer_if;
   import alu_op_sequencer_pkg::*;

   // issue side
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic [DATA_W-1:0] in_y;
   logic [OP_W-1:0]   in_opcode;
   // ALU side
   logic [DATA_W-1:0] alu_x;
   logic [DATA_W-1:0] alu_y;
   logic [OP_W-1:0]   alu_opcode;
   logic [DATA_W-1:0] alu_f;
   logic              alu_overflow;
   logic              alu_cout;
   logic              alu_zero;
   // result side
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_f;
   logic              out_overflow;
   logic              out_cout;
   logic              out_zero;
   logic              out_err;
   // status
   logic              busy;
   seq_state_t        dbg_state;

   modport slave (
      input  in_valid, in_x, in_y, in_opcode,
      input  alu_f, alu_overflow, alu_cout, alu_zero,
      input  out_ready,
      output in_ready, alu_x, alu_y, alu_opcode,
      output out_valid, out_f, out_overflow, out_cout, out_zero, out_err,
      output busy, dbg_state
   );

   modport master (
      output in_valid, in_x, in_y, in_opcode,
      output alu_f, alu_overflow, alu_cout, alu_zero,
      output out_ready,
      input  in_ready, alu_x, alu_y, alu_opcode,
      input  out_valid, out_f, out_overflow, out_cout, out_zero, out_err,
      input  busy, dbg_state
   );

endinterface

// File: rtl/alu_op_sequencer_settle_counter.sv
// Settle timer: cleared when an operation is launched, counts while enabled,
// and flags the terminal count SETTLE_CYCLES-1.
module alu_op_sequencer_settle_counter #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Count settle cycles; wrap to zero after the terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= done ? '0 : cnt + 1'b1;
      end
   end

   assign done = (cnt == LAST);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage around the combinational 32-bit ALU: registers one
// operation onto the ALU inputs, waits SETTLE_CYCLES for the ripple paths,
// then captures and presents the result. Illegal opcodes skip the ALU and
// return an error result straight away.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 4
) (
   input logic               clk,
   input logic               rst,
   alu_op_sequencer_if.slave bus
);

   seq_state_t state;
   logic       accept_legal;
   logic       cnt_en;
   logic       cnt_done;

   assign accept_legal  = (state == ST_IDLE) && bus.in_valid && op_legal(bus.in_opcode);
   assign cnt_en        = (state == ST_SETTLE);
   assign bus.dbg_state = state;

   alu_op_sequencer_settle_counter #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
   ) u_settle (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept_legal),
      .en   (cnt_en),
      .done (cnt_done)
   );

   // Sequencer FSM with registered ALU operands, result and handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= ST_IDLE;
         bus.in_ready     <= 1'b1;
         bus.busy         <= 1'b0;
         bus.alu_x        <= '0;
         bus.alu_y        <= '0;
         bus.alu_opcode   <= '0;
         bus.out_valid    <= 1'b0;
         bus.out_f        <= '0;
         bus.out_overflow <= 1'b0;
         bus.out_cout     <= 1'b0;
         bus.out_zero     <= 1'b0;
         bus.out_err      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  if (op_legal(bus.in_opcode)) begin
                     bus.alu_x      <= bus.in_x;
                     bus.alu_y      <= bus.in_y;
                     bus.alu_opcode <= bus.in_opcode;
                     state          <= ST_SETTLE;
                  end else begin
                     // ALU inputs stay untouched; report an error result.
                     bus.out_f        <= '0;
                     bus.out_overflow <= 1'b0;
                     bus.out_cout     <= 1'b0;
                     bus.out_zero     <= 1'b0;
                     bus.out_err      <= 1'b1;
                     bus.out_valid    <= 1'b1;
                     state            <= ST_DONE;
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_done) begin
                  bus.out_f        <= bus.alu_f;
                  bus.out_overflow <= bus.alu_overflow;
                  bus.out_cout     <= bus.alu_cout;
                  bus.out_zero     <= bus.alu_zero;
                  bus.out_err      <= 1'b0;
                  bus.out_valid    <= 1'b1;
                  state            <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Pop returns to IDLE; the next accept is one edge later.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state        <= ST_IDLE;
               bus.in_ready <= 1'b1;
               bus.busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU with a settle window sits on
// the ALU side; results are checked against a table of hand-derived vectors,
// hand-written corner sequences and a randomized run scored by an
// arithmetic reference model.
module tb_alu_op_sequencer;
   import alu_op_sequencer_pkg::*;

   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;

   logic [35:0] exp_q[$];

   alu_op_sequencer_if bus();

   alu_op_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .CNT_W         (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural ALU with ripple settle ----------------
   logic [66:0] alu_prev = '0;
   int          alu_age  = 0;
   logic [32:0] alu_sum;
   logic [31:0] alu_res;
   logic        alu_c;
   logic        alu_v;
   logic        alu_settled;

   // Track how long the ALU inputs have been stable.
   always @(posedge clk) begin
      if ({bus.alu_x, bus.alu_y, bus.alu_opcode} != alu_prev) begin
         alu_prev <= {bus.alu_x, bus.alu_y, bus.alu_opcode};
         alu_age  <= 0;
      end else if (alu_age < 15) begin
         alu_age <= alu_age + 1;
      end
   end

   // ALU function; outputs are inverted junk until the inputs have settled.
   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (bus.alu_opcode)
         OP_ADD: begin
            alu_sum = {1'b0, bus.alu_x} + {1'b0, bus.alu_y};
            alu_res = alu_sum[31:0];
            alu_c   = alu_sum[32];
            alu_v   = (bus.alu_x[31] == bus.alu_y[31]) && (alu_res[31] != bus.alu_x[31]);
         end
         OP_SUB: begin
            alu_sum = {1'b0, bus.alu_x} + {1'b0, ~bus.alu_y} + 33'd1;
            alu_res = alu_sum[31:0];
            alu_c   = alu_sum[32];
            alu_v   = (bus.alu_x[31] != bus.alu_y[31]) && (alu_res[31] != bus.alu_x[31]);
         end
         OP_OR:  alu_res = bus.alu_x | bus.alu_y;
         OP_AND: alu_res = bus.alu_x & bus.alu_y;
         OP_SLT: alu_res = ($signed(bus.alu_x) < $signed(bus.alu_y)) ? 32'd1 : 32'd0;
         default: alu_res = '0;
      endcase
      alu_settled = ({bus.alu_x, bus.alu_y, bus.alu_opcode} == alu_prev) && (alu_age >= SETTLE - 2);
      bus.alu_f        = alu_settled ? alu_res : ~alu_res;
      bus.alu_cout     = alu_settled ? alu_c : ~alu_c;
      bus.alu_overflow = alu_settled ? alu_v : ~alu_v;
      bus.alu_zero     = alu_settled ? (alu_res == 32'd0) : (alu_res != 32'd0);
   end

   // ---------------- reference model ----------------
   // Returns {err, zero, cout, overflow, f} from integer arithmetic.
   function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [2:0] op);
      longint ux, uy, sx, sy, r, s;
      logic [31:0] f;
      logic ov, c, e, z;
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      f = '0; ov = 1'b0; c = 1'b0; e = 1'b0; r = 0; s = 0;
      case (op)
         3'd0: begin
            r  = ux + uy;
            f  = r[31:0];
            c  = (r >= (64'sd1 <<< 32));
            s  = sx + sy;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd1: f = x | y;
         3'd2: f = x & y;
         3'd3: begin
            r  = ux - uy;
            f  = r[31:0];
            c  = (ux >= uy);
            s  = sx - sy;
            ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         3'd4: f = (sx < sy) ? 32'd1 : 32'd0;
         default: e = 1'b1;
      endcase
      z = e ? 1'b0 : (f == 32'd0);
      return {e, z, c, ov, f};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] dut_result();
      return {bus.out_err, bus.out_zero, bus.out_cout, bus.out_overflow, bus.out_f};
   endfunction

   // Launch one operation and wait for its result; lat = edges after accept.
   task automatic send_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [2:0] op, output int lat);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         step();
         guard++;
      end
      chk("accept_ready", 36'(bus.in_ready), 36'd1);
      bus.in_valid  = 1'b1;
      bus.in_x      = x;
      bus.in_y      = y;
      bus.in_opcode = op;
      step();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic pop();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      chk("pop_clears_valid", 36'(bus.out_valid), 36'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      logic [2:0]  op;
      logic [31:0] f;
      logic        ov;
      logic        c;
      logic        z;
      logic        err;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   // ---------------- main test ----------------
   initial begin
      int lat;
      int acc[$];
      int guard;
      int hold;
      int seen;
      logic [31:0] rx, ry, hold_f;
      logic [2:0]  rop;
      logic [35:0] e;

      bus.in_valid  = 1'b0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.in_opcode = '0;
      bus.out_ready = 1'b0;

      vecs[0]  = '{32'd1024, 32'd128, OP_ADD, 32'd1152, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[1]  = '{32'd5, 32'd5, OP_SUB, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, SETTLE};
      vecs[2]  = '{32'd3, 32'd7, OP_SLT, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[3]  = '{32'd7, 32'd3, OP_SLT, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, SETTLE};
      vecs[4]  = '{32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
      vecs[5]  = '{32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[6]  = '{32'hFFFF_FFFF, 32'd1, OP_ADD, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, SETTLE};
      vecs[7]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_OR, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[8]  = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[9]  = '{32'd3, 32'd5, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[10] = '{32'h8000_0000, 32'd1, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, SETTLE};
      vecs[11] = '{32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, SETTLE};
      vecs[12] = '{32'd0, 32'd0, OP_OR, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, SETTLE};
      vecs[13] = '{32'd1, 32'd1, 3'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};

      // Reset state
      step();
      step();
      chk("rst_out_valid", 36'(bus.out_valid), 36'd0);
      chk("rst_result", dut_result(), 36'd0);
      chk("rst_alu_ops", {bus.alu_opcode, bus.alu_x[31:0] | bus.alu_y[31:0]}, 36'd0);
      chk("rst_busy", 36'(bus.busy), 36'd0);
      rst = 1'b0;
      step();
      chk("rel_in_ready", 36'(bus.in_ready), 36'd1);
      chk("rel_state", 36'(bus.dbg_state), 36'(ST_IDLE));

      // out_ready with nothing to pop does nothing
      bus.out_ready = 1'b1;
      step();
      step();
      bus.out_ready = 1'b0;
      chk("idle_pop_valid", 36'(bus.out_valid), 36'd0);
      chk("idle_pop_ready", 36'(bus.in_ready), 36'd1);

      // Table-driven vectors
      for (int i = 0; i < 14; i++) begin
         send_op(vecs[i].x, vecs[i].y, vecs[i].op, lat);
         chk($sformatf("v%0d_lat", i), 36'(lat), 36'(vecs[i].lat));
         chk($sformatf("v%0d_result", i), dut_result(),
             {vecs[i].err, vecs[i].z, vecs[i].c, vecs[i].ov, vecs[i].f});
         chk($sformatf("v%0d_ready_in_done", i), 36'(bus.in_ready), 36'd0);
         pop();
      end

      // Illegal opcode leaves the ALU inputs at the last legal operation
      send_op(32'd1024, 32'd128, OP_ADD, lat);
      pop();
      send_op(32'd99, 32'd77, 3'd6, lat);
      chk("illegal_lat", 36'(lat), 36'd0);
      chk("illegal_err", 36'(bus.out_err), 36'd1);
      chk("illegal_alu_opcode", 36'(bus.alu_opcode), 36'(OP_ADD));
      chk("illegal_alu_x", 36'(bus.alu_x), 36'd1024);
      chk("illegal_alu_y", 36'(bus.alu_y), 36'd128);
      pop();

      // Back-pressure in DONE while in_valid pulses
      send_op(32'd100, 32'd1, OP_SUB, lat);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid  = (i % 2) == 0;
         bus.in_x      = $urandom;
         bus.in_y      = $urandom;
         bus.in_opcode = 3'($urandom_range(0, 4));
         step();
         chk($sformatf("hold%0d_in_ready", i), 36'(bus.in_ready), 36'd0);
         chk($sformatf("hold%0d_valid", i), 36'(bus.out_valid), 36'd1);
         chk($sformatf("hold%0d_f", i), 36'(bus.out_f), 36'd99);
         chk($sformatf("hold%0d_alu_x", i), 36'(bus.alu_x), 36'd100);
      end
      // Pop with in_valid high: no accept on the pop edge
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'd55;
      bus.in_opcode = OP_ADD;
      bus.out_ready = 1'b1;
      step();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("pop_no_accept_busy", 36'(bus.busy), 36'd0);
      chk("pop_no_accept_alu_x", 36'(bus.alu_x), 36'd100);
      chk("pop_no_accept_valid", 36'(bus.out_valid), 36'd0);

      // Throughput with out_ready held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'd1;
      bus.in_y      = 32'd2;
      bus.in_opcode = OP_ADD;
      for (int i = 0; i < 20; i++) begin
         if (bus.in_ready) acc.push_back(i);
         step();
      end
      bus.in_valid = 1'b0;
      chk("tput_accepts", 36'(acc.size() >= 3), 36'd1);
      if (acc.size() >= 3) begin
         chk("tput_gap1", 36'(acc[1] - acc[0]), 36'(SETTLE + 2));
         chk("tput_gap2", 36'(acc[2] - acc[1]), 36'(SETTLE + 2));
      end
      guard = 0;
      while (bus.busy && guard < 50) begin
         step();
         guard++;
      end
      bus.out_ready = 1'b0;
      chk("tput_drain", 36'(bus.busy), 36'd0);

      // Reset two cycles into SETTLE
      send_op(32'd1024, 32'd128, OP_ADD, lat);
      pop();
      bus.in_valid  = 1'b1;
      bus.in_x      = 32'd7;
      bus.in_y      = 32'd9;
      bus.in_opcode = OP_ADD;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", 36'(bus.out_valid), 36'd0);
      chk("mid_rst_result", dut_result(), 36'd0);
      chk("mid_rst_alu_x", 36'(bus.alu_x), 36'd0);
      chk("mid_rst_alu_y", 36'(bus.alu_y), 36'd0);
      chk("mid_rst_busy", 36'(bus.busy), 36'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("mid_rel_in_ready", 36'(bus.in_ready), 36'd1);
      chk("mid_rel_state", 36'(bus.dbg_state), 36'(ST_IDLE));
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid) seen++;
         step();
      end
      chk("mid_rel_no_partial", 36'(seen), 36'd0);
      send_op(32'd20, 32'd5, OP_SUB, lat);
      chk("post_rst_lat", 36'(lat), 36'(SETTLE));
      chk("post_rst_result", dut_result(), model(32'd20, 32'd5, OP_SUB));
      pop();

      // Randomized operations scored against the reference model
      for (int n = 0; n < 40; n++) begin
         rx  = pick();
         ry  = pick();
         rop = 3'($urandom_range(0, 7));
         exp_q.push_back(model(rx, ry, rop));
         send_op(rx, ry, rop, lat);
         chk($sformatf("rnd%0d_lat", n), 36'(lat), (rop <= 3'd4) ? 36'(SETTLE) : 36'd0);
         hold_f = bus.out_f;
         hold = $urandom_range(0, 3);
         repeat (hold) step();
         chk($sformatf("rnd%0d_stable", n), 36'(bus.out_f), 36'(hold_f));
         e = exp_q.pop_front();
         chk($sformatf("rnd%0d_result", n), dut_result(), e);
         pop();
      end
      chk("queue_empty", 36'(exp_q.size()), 36'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
